// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit driving the {HI, LO} result pair.
// Define MULDIV_DIV_EN to compile in the unsigned divide path (op = 2'b10).
module muldiv_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [ITER-1:0]       src_a,
  input  logic [ITER-1:0]       src_b,
  output logic                  busy,
  output logic                  done,
  output logic [2*ITER-1:0]     result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_CALC   = 2'b01,
    S_FINISH = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10
  } op_t;

  localparam logic [5:0] LAST = 6'(ITER - 1);

  state_t              state, state_next;
  op_t                 op_q;
  logic [5:0]          cnt;
  logic                neg;
  logic [2*ITER-1:0]   acc;
  logic [2*ITER-1:0]   mcand;
  logic [ITER-1:0]     mplier;
  logic                legal;
  logic                accept;
  logic                is_mult;
  logic [ITER-1:0]     mag_a, mag_b;

  always_comb begin
    legal = (op == OP_MULTU) || (op == OP_MULT);
`ifdef MULDIV_DIV_EN
    if (op == OP_DIVU) legal = 1'b1;
`endif
  end

  assign accept  = (state == S_IDLE) && start && legal;
  assign is_mult = (op == OP_MULT);
  assign mag_a   = (is_mult && src_a[ITER-1]) ? -src_a : src_a;
  assign mag_b   = (is_mult && src_b[ITER-1]) ? -src_b : src_b;
  assign busy    = (state != S_IDLE);

`ifdef MULDIV_DIV_EN
  // Remainder lives in acc[HI], dividend/quotient in acc[LO]; the divisor reuses mplier.
  logic [ITER:0]   shifted;
  logic [ITER+1:0] diff;
  assign shifted = acc[2*ITER-1:ITER-1];
  assign diff    = {1'b0, shifted} - {2'b00, mplier};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (accept) state_next = S_CALC;
      S_CALC:   if (cnt == LAST) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= OP_MULTU;
      cnt    <= '0;
      neg    <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op_t'(op);
            cnt    <= '0;
            neg    <= is_mult && (src_a[ITER-1] ^ src_b[ITER-1]);
            mcand  <= {{ITER{1'b0}}, mag_a};
            mplier <= mag_b;
            acc    <= '0;
`ifdef MULDIV_DIV_EN
            if (op == OP_DIVU) acc <= {{ITER{1'b0}}, src_a};
`endif
          end
        end
        S_CALC: begin
          cnt <= cnt + 6'd1;
`ifdef MULDIV_DIV_EN
          if (op_q == OP_DIVU) begin
            if (!diff[ITER+1]) acc <= {diff[ITER-1:0], acc[ITER-2:0], 1'b1};
            else               acc <= {acc[2*ITER-2:0], 1'b0};
          end else
`endif
          begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
        end
        S_FINISH: begin
          result <= neg ? -acc : acc;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and
// checked (value and completion cycle) by an independent monitor on done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy;
  logic        done;
  logic [63:0] result;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!reset && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no completion", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check64("result", result, e.val);
        check64("done_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expv);
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0;
    e.val = expv;
    e.due = cyc + 33;
    sb.push_back(e);
  endtask

  task automatic issue_ignored(input logic [1:0] o, input string name);
    @(negedge clk);
    start = 1'b1; op = o; src_a = 32'd9; src_b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    check64(name, {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check64("idle_result", result, 64'h0);
      check64("idle_busy", {63'd0, busy}, 64'd0);
      check64("idle_done", {63'd0, done}, 64'd0);
    end

    issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    check64("busy_in_calc", {63'd0, busy}, 64'd1);
    wait_done("multu_max");

    issue(2'b01, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1);
    wait_done("mult_neg");
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    wait_done("mult_min");
    check64("result_held", result, 64'h4000_0000_0000_0000);

`ifdef MULDIV_DIV_EN
    issue(2'b10, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    wait_done("divu");
    issue(2'b10, 32'h1234, 32'd0, 64'h0000_1234_FFFF_FFFF);
    wait_done("divu_zero");
`else
    issue_ignored(2'b10, "divu_disabled_ignored");
`endif
    issue_ignored(2'b11, "reserved_ignored");

    // Extra start mid-operation must not disturb the result.
    issue(2'b00, 32'd3, 32'd4, 64'd12);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    check64("busy_after_restart", {63'd0, busy}, 64'd1);
    wait_done("restart_ignored");
    check64("prior_result", result, 64'd12);

    // Reset mid-CALC discards the operation.
    issue(2'b00, 32'd7, 32'd6, 64'd42);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b0;
    check64("rst_result", result, 64'h0);
    check64("rst_busy", {63'd0, busy}, 64'd0);
    check64("rst_done", {63'd0, done}, 64'd0);
    repeat (40) @(negedge clk);
    check64("rst_no_done_result", result, 64'h0);

    issue(2'b00, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
    wait_done("after_reset");
    issue(2'b01, 32'd6, 32'hFFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFD6);
    wait_done("mult_neg_b");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t, expected completion earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
